// File: rtl/pc_npc_sequencer_if.sv
// Bus between the control unit and the PC/nPC sequencer: retire/trap requests
// flow towards the sequencer, PC/nPC state and writeback pulses flow back.
interface pc_npc_sequencer_if #(
  parameter int ADDR_WIDTH = 32
);
  // Control unit -> sequencer
  logic                   advance;
  logic [2:0]             op;
  logic [29:0]            disp30;
  logic [21:0]            disp22;
  logic                   annul_bit;
  logic                   br_always;
  logic [ADDR_WIDTH-1:0]  jmp_target;
  logic                   trap_req;
  logic [7:0]             trap_tt;
  logic                   et;
  logic [ADDR_WIDTH-13:0] tbr_base;

  // Sequencer -> control unit / register file
  logic                   ready;
  logic [ADDR_WIDTH-1:0]  pc;
  logic [ADDR_WIDTH-1:0]  npc;
  logic                   annul_next;
  logic                   link_we;
  logic [ADDR_WIDTH-1:0]  link_data;
  logic                   trap_save_we;
  logic [ADDR_WIDTH-1:0]  saved_pc;
  logic [ADDR_WIDTH-1:0]  saved_npc;
  logic                   rett_pulse;
  logic                   error_mode;

  modport master (
    output advance, op, disp30, disp22, annul_bit, br_always, jmp_target,
           trap_req, trap_tt, et, tbr_base,
    input  ready, pc, npc, annul_next, link_we, link_data, trap_save_we,
           saved_pc, saved_npc, rett_pulse, error_mode
  );

  modport slave (
    input  advance, op, disp30, disp22, annul_bit, br_always, jmp_target,
           trap_req, trap_tt, et, tbr_base,
    output ready, pc, npc, annul_next, link_we, link_data, trap_save_we,
           saved_pc, saved_npc, rett_pulse, error_mode
  );
endinterface

// File: rtl/pc_npc_sequencer.sv
// SPARC V8 PC/nPC sequencer: delayed control transfer, delay-slot annulment
// and two-cycle trap entry through a TBR-formed vector. The interface
// instance must use the same ADDR_WIDTH as this module.
module pc_npc_sequencer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [7:0]            TT_ALIGN   = 8'h07
) (
  input  logic                  Clk,
  input  logic                  RESET,
  pc_npc_sequencer_if.slave     bus
);

  typedef enum logic [2:0] {
    S_INIT, S_RUN, S_TRAP_SAVE, S_TRAP_VEC, S_ERROR
  } state_e;

  typedef enum logic [2:0] {
    OP_SEQ, OP_CALL, OP_BR_TAKEN, OP_BR_NOT_TAKEN, OP_JMPL, OP_RETT
  } op_e;

  // Wide enough to hold a sign-extended 32-bit byte displacement.
  localparam int EXT_W = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_pc, r_npc;
  logic                  r_annul;
  logic                  r_link_we, r_trap_save_we, r_rett;
  logic [ADDR_WIDTH-1:0] r_link_data, r_saved_pc, r_saved_npc;
  logic [7:0]            r_tt;

  state_e                w_nxt_state;
  logic [ADDR_WIDTH-1:0] w_nxt_pc, w_nxt_npc;
  logic                  w_nxt_annul;
  logic                  w_nxt_link_we, w_nxt_trap_save_we, w_nxt_rett;
  logic [ADDR_WIDTH-1:0] w_nxt_link_data, w_nxt_saved_pc, w_nxt_saved_npc;
  logic [7:0]            w_nxt_tt;
  logic                  w_take_trap;
  logic [7:0]            w_trap_tt;

  logic [EXT_W-1:0]      w_call_ext, w_br_ext;
  logic [ADDR_WIDTH-1:0] w_call_off, w_br_off, w_step_npc, w_vector;
  logic                  w_misaligned;

  // Word displacements become sign-extended byte offsets.
  assign w_call_ext   = EXT_W'($signed({bus.disp30, 2'b00}));
  assign w_br_ext     = EXT_W'($signed({{8{bus.disp22[21]}}, bus.disp22, 2'b00}));
  assign w_call_off   = w_call_ext[ADDR_WIDTH-1:0];
  assign w_br_off     = w_br_ext[ADDR_WIDTH-1:0];
  assign w_step_npc   = r_npc + ADDR_WIDTH'(4);
  assign w_vector     = {bus.tbr_base, r_tt, 4'b0000};
  assign w_misaligned = (bus.jmp_target[1:0] != 2'b00);

  // Next-state, next-PC/nPC and side-effect pulse decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_nxt_state        = r_state;
    w_nxt_pc           = r_pc;
    w_nxt_npc          = r_npc;
    w_nxt_annul        = r_annul;
    w_nxt_link_we      = 1'b0;
    w_nxt_trap_save_we = 1'b0;
    w_nxt_rett         = 1'b0;
    w_nxt_link_data    = r_link_data;
    w_nxt_saved_pc     = r_saved_pc;
    w_nxt_saved_npc    = r_saved_npc;
    w_nxt_tt           = r_tt;
    w_take_trap        = 1'b0;
    w_trap_tt          = bus.trap_tt;

    case (r_state)
      S_INIT: w_nxt_state = S_RUN;

      S_RUN: begin
        if (bus.trap_req) begin
          w_take_trap = 1'b1;
        end else if (bus.advance) begin
          if (r_annul) begin
            // Squashed delay slot: step only, no side effects.
            w_nxt_pc    = r_npc;
            w_nxt_npc   = w_step_npc;
            w_nxt_annul = 1'b0;
          end else begin
            case (bus.op)
              OP_CALL: begin
                w_nxt_link_data = r_pc;
                w_nxt_link_we   = 1'b1;
                w_nxt_pc        = r_npc;
                w_nxt_npc       = r_pc + w_call_off;
              end
              OP_BR_TAKEN: begin
                w_nxt_pc    = r_npc;
                w_nxt_npc   = r_pc + w_br_off;
                w_nxt_annul = bus.annul_bit & bus.br_always;
              end
              OP_BR_NOT_TAKEN: begin
                w_nxt_pc    = r_npc;
                w_nxt_npc   = w_step_npc;
                w_nxt_annul = bus.annul_bit;
              end
              OP_JMPL, OP_RETT: begin
                if (w_misaligned) begin
                  w_take_trap = 1'b1;
                  w_trap_tt   = TT_ALIGN;
                end else begin
                  w_nxt_pc  = r_npc;
                  w_nxt_npc = bus.jmp_target;
                  if (bus.op == OP_JMPL) begin
                    w_nxt_link_data = r_pc;
                    w_nxt_link_we   = 1'b1;
                  end else begin
                    w_nxt_rett = 1'b1;
                  end
                end
              end
              default: begin  // SEQ and the unused encodings
                w_nxt_pc  = r_npc;
                w_nxt_npc = w_step_npc;
              end
            endcase
          end
        end

        // Trap entry overrides whatever the advance would have done.
        if (w_take_trap) begin
          w_nxt_annul = 1'b0;
          if (!bus.et) begin
            w_nxt_state = S_ERROR;
          end else begin
            w_nxt_state        = S_TRAP_SAVE;
            w_nxt_saved_pc     = r_pc;
            w_nxt_saved_npc    = r_npc;
            w_nxt_tt           = w_trap_tt;
            w_nxt_trap_save_we = 1'b1;
          end
        end
      end

      S_TRAP_SAVE: w_nxt_state = S_TRAP_VEC;

      S_TRAP_VEC: begin
        w_nxt_pc    = w_vector;
        w_nxt_npc   = w_vector + ADDR_WIDTH'(4);
        w_nxt_state = S_RUN;
      end

      S_ERROR: w_nxt_state = S_ERROR;

      default: w_nxt_state = S_INIT;
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clk or posedge RESET) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (RESET) begin
      r_state        <= S_INIT;
      r_pc           <= RESET_PC;
      r_npc          <= RESET_PC + ADDR_WIDTH'(4);
      r_annul        <= 1'b0;
      r_link_we      <= 1'b0;
      r_trap_save_we <= 1'b0;
      r_rett         <= 1'b0;
      r_link_data    <= '0;
      r_saved_pc     <= '0;
      r_saved_npc    <= '0;
      r_tt           <= '0;
    end else begin
      r_state        <= w_nxt_state;
      r_pc           <= w_nxt_pc;
      r_npc          <= w_nxt_npc;
      r_annul        <= w_nxt_annul;
      r_link_we      <= w_nxt_link_we;
      r_trap_save_we <= w_nxt_trap_save_we;
      r_rett         <= w_nxt_rett;
      r_link_data    <= w_nxt_link_data;
      r_saved_pc     <= w_nxt_saved_pc;
      r_saved_npc    <= w_nxt_saved_npc;
      r_tt           <= w_nxt_tt;
    end
  end

  assign bus.ready        = (r_state == S_RUN);
  assign bus.error_mode   = (r_state == S_ERROR);
  assign bus.pc           = r_pc;
  assign bus.npc          = r_npc;
  assign bus.annul_next   = r_annul;
  assign bus.link_we      = r_link_we;
  assign bus.link_data    = r_link_data;
  assign bus.trap_save_we = r_trap_save_we;
  assign bus.saved_pc     = r_saved_pc;
  assign bus.saved_npc    = r_saved_npc;
  assign bus.rett_pulse   = r_rett;

endmodule
